// File: rtl/morse_pkg.sv
// Shared definitions for the streaming Morse transmitter: FSM state codes,
// element lengths, the ASCII-to-Morse encoder and the FIFO level width helper.
package morse_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_LOAD     = 3'd1;
    localparam state_t ST_MARK     = 3'd2;
    localparam state_t ST_ELEM_GAP = 3'd3;
    localparam state_t ST_CHAR_GAP = 3'd4;
    localparam state_t ST_WORD_GAP = 3'd5;

    localparam int DIT      = 1;
    localparam int DAH      = 3;
    localparam int ELEM_GAP = 1;

    // pattern is right-aligned, first element in bit (length-1), 1 = dah
    typedef struct packed {
        logic       valid;
        logic       is_space;
        logic [2:0] length;
        logic [4:0] pattern;
    } morse_code_t;

    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic morse_code_t mk(input logic [2:0] len, input logic [4:0] pat);
        morse_code_t r;
        r.valid    = 1'b1;
        r.is_space = 1'b0;
        r.length   = len;
        r.pattern  = pat;
        return r;
    endfunction

    function automatic morse_code_t encode(input logic [7:0] c);
        morse_code_t r;
        logic [7:0]  u;
        r = '0;
        u = (c >= "a" && c <= "z") ? c - 8'h20 : c;
        case (u)
            8'h20: begin r.valid = 1'b1; r.is_space = 1'b1; end
            "A": r = mk(3'd2, 5'b00001);
            "B": r = mk(3'd4, 5'b01000);
            "C": r = mk(3'd4, 5'b01010);
            "D": r = mk(3'd3, 5'b00100);
            "E": r = mk(3'd1, 5'b00000);
            "F": r = mk(3'd4, 5'b00010);
            "G": r = mk(3'd3, 5'b00110);
            "H": r = mk(3'd4, 5'b00000);
            "I": r = mk(3'd2, 5'b00000);
            "J": r = mk(3'd4, 5'b00111);
            "K": r = mk(3'd3, 5'b00101);
            "L": r = mk(3'd4, 5'b00100);
            "M": r = mk(3'd2, 5'b00011);
            "N": r = mk(3'd2, 5'b00010);
            "O": r = mk(3'd3, 5'b00111);
            "P": r = mk(3'd4, 5'b00110);
            "Q": r = mk(3'd4, 5'b01101);
            "R": r = mk(3'd3, 5'b00010);
            "S": r = mk(3'd3, 5'b00000);
            "T": r = mk(3'd1, 5'b00001);
            "U": r = mk(3'd3, 5'b00001);
            "V": r = mk(3'd4, 5'b00001);
            "W": r = mk(3'd3, 5'b00011);
            "X": r = mk(3'd4, 5'b01001);
            "Y": r = mk(3'd4, 5'b01011);
            "Z": r = mk(3'd4, 5'b01100);
            "0": r = mk(3'd5, 5'b11111);
            "1": r = mk(3'd5, 5'b01111);
            "2": r = mk(3'd5, 5'b00111);
            "3": r = mk(3'd5, 5'b00011);
            "4": r = mk(3'd5, 5'b00001);
            "5": r = mk(3'd5, 5'b00000);
            "6": r = mk(3'd5, 5'b10000);
            "7": r = mk(3'd5, 5'b11000);
            "8": r = mk(3'd5, 5'b11100);
            "9": r = mk(3'd5, 5'b11110);
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic supported(input logic [7:0] c);
        morse_code_t r;
        r = encode(c);
        return r.valid;
    endfunction

endpackage

// File: rtl/morse_fifo.sv
// Synchronous character FIFO with registered full/empty/level status.
module morse_fifo
    import morse_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW    = 8
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic [DW-1:0]             din,
    output logic [DW-1:0]             dout,
    output logic                      full,
    output logic                      empty,
    output logic [level_w(DEPTH)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push, do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        full_d  = (level_d == LW'(DEPTH));
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // storage needs no reset; pointers define what is valid
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign level = level_q;

endmodule

// File: rtl/morse_tx_stream.sv
// Streaming ASCII-to-Morse keyer: handshake into a FIFO, then timed on/off keying.
// Optional Farnsworth gap stretching via macro MORSE_TX_FARNSWORTH_EN.
//
// state     | meaning
// IDLE      | waiting for FIFO data; pops one character
// LOAD      | encode popped character, pick first element
// MARK      | tone on for DIT or DAH units
// ELEM_GAP  | tone off one unit between elements
// CHAR_GAP  | tone off after last element of a character
// WORD_GAP  | tone off for a space token
module morse_tx_stream
    import morse_pkg::*;
#(
    parameter int PRESCALER  = 1_000_000,
    parameter int FIFO_DEPTH = 16,
    parameter int CHAR_GAP   = 3,
    parameter int WORD_GAP   = 7
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic [7:0]                   ascii_in,
    input  logic                         ascii_valid,
`ifdef MORSE_TX_FARNSWORTH_EN
    input  logic [3:0]                   gap_extra,
`endif
    output logic                         ascii_ready,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(FIFO_DEPTH):0]  level,
    output logic                         busy,
    output logic                         bad_char,
    output logic                         morse_out
);

    localparam int            PW       = $clog2(PRESCALER);
    localparam logic [PW-1:0] PRESC_TC = PW'(PRESCALER - 1);
    localparam logic [7:0]    DIT_U    = 8'(DIT);
    localparam logic [7:0]    DAH_U    = 8'(DAH);
    localparam logic [7:0]    EG_U     = 8'(ELEM_GAP);
    localparam logic [7:0]    CG_U     = 8'(CHAR_GAP);
    localparam logic [7:0]    WG_U     = 8'(WORD_GAP - CHAR_GAP);

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    units_q, units_d;
    logic [4:0]    pattern_q, pattern_d;
    logic [2:0]    len_q, len_d;
    logic [7:0]    char_q, char_d;
    logic          bad_char_q, bad_char_d;
    logic          morse_out_q, morse_out_d;

    logic          accept, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic          unit_tc;
    logic [3:0]    extra_ld, extra_cur;
    morse_code_t   load_code;

`ifdef MORSE_TX_FARNSWORTH_EN
    logic [3:0] extra_q, extra_d;

    always_comb begin
        extra_d = (state_q == ST_LOAD) ? gap_extra : extra_q;
    end

    always_ff @(posedge clk) begin
        if (!arst_n) extra_q <= 4'd0;
        else         extra_q <= extra_d;
    end

    assign extra_ld  = gap_extra;
    assign extra_cur = extra_q;
`else
    assign extra_ld  = 4'd0;
    assign extra_cur = 4'd0;
`endif

    assign accept     = ascii_valid && !fifo_full;
    assign fifo_push  = accept && supported(ascii_in);
    assign bad_char_d = accept && !supported(ascii_in) && (ascii_in != 8'h00);

    morse_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (8)
    ) u_fifo (
        .clk    (clk),
        .arst_n (arst_n),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .din    (ascii_in),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (level)
    );

    assign load_code = encode(char_q);
    assign unit_tc   = (presc_q == PRESC_TC);

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        units_d   = units_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        char_d    = char_q;
        fifo_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                presc_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    char_d   = fifo_dout;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                presc_d = '0;
                if (!load_code.valid) begin
                    state_d = ST_IDLE;
                end else if (load_code.is_space) begin
                    state_d = ST_WORD_GAP;
                    units_d = WG_U + {4'd0, extra_ld};
                end else begin
                    // left-align so the current element is always bit 4
                    pattern_d = load_code.pattern << (3'd5 - load_code.length);
                    len_d     = load_code.length;
                    units_d   = pattern_d[4] ? DAH_U : DIT_U;
                    state_d   = ST_MARK;
                end
            end
            default: begin
                presc_d = unit_tc ? '0 : presc_q + PW'(1);
                if (unit_tc) begin
                    if (units_q != 8'd1) begin
                        units_d = units_q - 8'd1;
                    end else begin
                        case (state_q)
                            ST_MARK: begin
                                pattern_d = pattern_q << 1;
                                len_d     = len_q - 3'd1;
                                if (len_q > 3'd1) begin
                                    state_d = ST_ELEM_GAP;
                                    units_d = EG_U;
                                end else begin
                                    state_d = ST_CHAR_GAP;
                                    units_d = CG_U + {4'd0, extra_cur};
                                end
                            end
                            ST_ELEM_GAP: begin
                                state_d = ST_MARK;
                                units_d = pattern_q[4] ? DAH_U : DIT_U;
                            end
                            default: state_d = ST_IDLE;
                        endcase
                    end
                end
            end
        endcase
        // output is registered, so keying lags the state by one cycle
        morse_out_d = (state_q == ST_MARK);
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            units_q     <= '0;
            pattern_q   <= '0;
            len_q       <= '0;
            char_q      <= '0;
            bad_char_q  <= 1'b0;
            morse_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            units_q     <= units_d;
            pattern_q   <= pattern_d;
            len_q       <= len_d;
            char_q      <= char_d;
            bad_char_q  <= bad_char_d;
            morse_out_q <= morse_out_d;
        end
    end

    assign ascii_ready = !fifo_full;
    assign full        = fifo_full;
    assign empty       = fifo_empty;
    assign busy        = (state_q != ST_IDLE);
    assign bad_char    = bad_char_q;
    assign morse_out   = morse_out_q;

endmodule

// File: tb/tb_morse_tx_stream.sv
// Directed and randomized bench for morse_tx_stream against a dot/dash string model.
module tb_morse_tx_stream;

    localparam int P  = 4;
    localparam int D  = 16;
    localparam int CG = 3;
    localparam int WG = 7;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic [7:0] ascii_in = 8'h00;
    logic       ascii_valid = 1'b0;
    logic       ascii_ready, full, empty, busy, bad_char, morse_out;
    logic [4:0] level;

    int checks = 0;
    int errors = 0;

    string tbl [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                        ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                        "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                        "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                        "--...", "---..", "----."};

    morse_tx_stream #(
        .PRESCALER  (P),
        .FIFO_DEPTH (D),
        .CHAR_GAP   (CG),
        .WORD_GAP   (WG)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .ascii_in    (ascii_in),
        .ascii_valid (ascii_valid),
        .ascii_ready (ascii_ready),
        .full        (full),
        .empty       (empty),
        .level       (level),
        .busy        (busy),
        .bad_char    (bad_char),
        .morse_out   (morse_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // -2 space, -1 unsupported, else index into tbl
    function automatic int cls(input byte unsigned c);
        byte unsigned u;
        u = c;
        if (u >= "a" && u <= "z") u = u - 8'd32;
        if (u == 8'h20) return -2;
        if (u >= "A" && u <= "Z") return int'(u - 8'h41);
        if (u >= "0" && u <= "9") return 26 + int'(u - 8'h30);
        return -1;
    endfunction

    task automatic check_idle_status(input string name);
        check({name, " empty"}, empty, 1);
        check({name, " level"}, level, 0);
        check({name, " busy"}, busy, 0);
        check({name, " full"}, full, 0);
        check({name, " ready"}, ascii_ready, 1);
    endtask

    // Offers seq on consecutive edges from idle; compares every cycle against the model.
    task automatic run_seq(input byte unsigned seq[$], input string name);
        int  st[$];      // per cycle: 0 idle, 1 busy with tone off, 2 tone on
        bit  bad[$];
        int  n, first, c;
        string s;
        n = seq.size();
        first = -1;
        for (int j = 0; j < n; j++) begin
            bad.push_back(cls(seq[j]) == -1 && seq[j] != 8'h00);
            if (first < 0 && cls(seq[j]) != -1) first = j;
        end
        if (first < 0) begin
            repeat (n + 4) st.push_back(0);
        end else begin
            repeat (first) st.push_back(0);
            for (int j = first; j < n; j++) begin
                c = cls(seq[j]);
                if (c == -1) continue;
                st.push_back(0);
                st.push_back(1);
                if (c == -2) begin
                    repeat ((WG - CG) * P) st.push_back(1);
                end else begin
                    s = tbl[c];
                    for (int i = 0; i < s.len(); i++) begin
                        repeat ((s[i] == "-" ? 3 : 1) * P) st.push_back(2);
                        if (i < s.len() - 1) repeat (P) st.push_back(1);
                    end
                    repeat (CG * P) st.push_back(1);
                end
            end
            repeat (4) st.push_back(0);
        end
        ascii_in = seq[0];
        ascii_valid = 1'b1;
        for (int k = 0; k < st.size(); k++) begin
            if (k < n) check($sformatf("%s ready k=%0d", name, k), ascii_ready, 1);
            tick();
            check($sformatf("%s morse k=%0d", name, k), morse_out, (k == 0) ? 0 : (st[k-1] == 2));
            check($sformatf("%s busy k=%0d", name, k), busy, st[k] != 0);
            check($sformatf("%s bad k=%0d", name, k), bad_char, (k < n) ? bad[k] : 1'b0);
            if (k + 1 < n) ascii_in = seq[k+1];
            else ascii_valid = 1'b0;
        end
        check_idle_status(name);
    endtask

    initial begin
        byte unsigned q[$];
        int acc;
        int r;
        string cset;

        arst_n = 1'b0;
        tick();
        tick();
        check("reset morse", morse_out, 0);
        check("reset bad", bad_char, 0);
        check_idle_status("reset");
        arst_n = 1'b1;
        tick();

        q = '{"E"};              run_seq(q, "E");
        q = '{"a"};              run_seq(q, "a");
        q = '{"A"};              run_seq(q, "A");
        q = '{"E", " ", "E"};    run_seq(q, "E_E");
        q = '{"#", 8'h00};       run_seq(q, "bad");

        // fill the FIFO by holding valid
        ascii_in = "T";
        ascii_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 24; i++) begin
            if (ascii_ready) acc++;
            tick();
        end
        ascii_valid = 1'b0;
        check("fill accepted", acc, 17);
        check("fill full", full, 1);
        check("fill level", level, 16);
        check("fill ready", ascii_ready, 0);
        check("fill empty", empty, 0);
        for (int i = 0; i < 40 && level == 5'd16; i++) tick();
        check("fill first pop level", level, 15);
        check("fill not full", full, 0);

        arst_n = 1'b0;
        tick();
        arst_n = 1'b1;
        check("flush morse", morse_out, 0);
        check_idle_status("flush");

        // reset in the middle of the first dah of "0"
        ascii_in = "0";
        ascii_valid = 1'b1;
        tick();
        ascii_valid = 1'b0;
        repeat (8) tick();
        check("mid-dah morse", morse_out, 1);
        check("mid-dah busy", busy, 1);
        arst_n = 1'b0;
        tick();
        arst_n = 1'b1;
        check("rst mid-dah morse", morse_out, 0);
        check_idle_status("rst mid-dah");
        q = '{"E"};              run_seq(q, "E after reset");

        cset = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";
        for (int t = 0; t < 8; t++) begin
            q.delete();
            r = $urandom_range(1, 4);
            for (int i = 0; i < r; i++) begin
                case ($urandom_range(0, 9))
                    0: q.push_back(byte'($urandom_range(33, 47)));
                    1: q.push_back(8'h20);
                    2: q.push_back(8'h00);
                    default: begin
                        q.push_back(cset[$urandom_range(0, 35)]);
                        if (q[i] >= "A" && $urandom_range(0, 1) == 1) q[i] = q[i] + 8'd32;
                    end
                endcase
            end
            run_seq(q, $sformatf("rand%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
